i2s_xmtr: RTL and testbench
===========================

Name: i2s_xmtr

Overview:
- Master-mode I2S transmitter: generates I2S_sclk, I2S_ws and I2S_data from 24-bit left/right sample pairs supplied over a valid/ready handshake.
- Drives the same three-wire bus the Equalizer's I2S receiver consumes. Used as the synthesizable audio source behind the RN52 model and for loopback self-test.
- One-deep holding register decouples the producer from frame timing.

Parameters:
- SCLK_HALF, 16, clk cycles per half period of I2S_sclk (legal >= 2); frame = 128*SCLK_HALF clks.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- lft_smpl  in  24  left sample, two's complement
- rght_smpl  in  24  right sample, two's complement
- smpl_vld  in  1  producer has a sample pair
- smpl_rdy  out  1  holding register empty (level)
- I2S_sclk  out  1  serial bit clock
- I2S_ws  out  1  word select, 0 = left, 1 = right
- I2S_data  out  1  serial data, MSB first
- frame_start  out  1  1-clk pulse when a new frame is loaded
- underrun  out  1  1-clk pulse when a frame is loaded with the holding register empty

Behaviour:
- Reset values:
  - I2S_sclk = 0, I2S_ws = 1, I2S_data = 0
  - smpl_rdy = 1, frame_start = 0, underrun = 0
  - internal: div_cnt = 0, bit_cnt = 63, hold_full = 0, shift register = 0
- Clock generation:
  - div_cnt counts 0..SCLK_HALF-1. At terminal count, I2S_sclk toggles and div_cnt wraps to 0.
  - A falling edge is the toggle 1->0. First rise is SCLK_HALF clks after reset release; first fall is 2*SCLK_HALF clks after.
- Bit counter:
  - 6-bit bit_cnt increments on every sclk falling edge and wraps 63->0.
  - In the same clk, I2S_ws <= new bit_cnt[5].
- Frame vector:
  - F[63:0] = {1'b0, L[23:0], 7'b0, 1'b0, R[23:0], 7'b0}, giving the standard one-sclk MSB delay after each ws transition.
  - On each falling edge, I2S_data <= F[63 - new bit_cnt], implemented as a 64-bit shift register shifted left on each falling edge.
- Frame load (falling edge where bit_cnt wraps to 0):
  - If hold_full: F is built from the holding register; hold_full <= 0.
  - If hold empty: F = 0 and underrun pulses.
  - frame_start pulses in the same clk in both cases.
- Data stability: all outputs change only in the clk of an sclk falling edge, so data is stable at the sclk rising edge.
- Handshake:
  - smpl_rdy = ~hold_full.
  - Capture occurs when smpl_vld & smpl_rdy: hold <= {lft_smpl, rght_smpl}, hold_full <= 1 next clk.
  - No capture while full; the producer must hold smpl_vld and its data.
- Simultaneous capture and load with hold empty: the capture fills hold for the NEXT frame. The current frame is zeros and underrun pulses.
- Reset mid-frame: all state returns to reset values within one clk, the pending sample is discarded, and the bus restarts from the first-fall sequence.
- Samples are passed through bit-exact; no arithmetic, no saturation.

Decomposition:
- Package i2s_pkg:
  - SMPL_W = 24, SLOT_W = 32, FRAME_BITS = 64
  - typedef smpl_pair_t {logic [23:0] lft; logic [23:0] rght;}
- Sub-module i2s_clk_gen:
  - Contains div_cnt, I2S_sclk, the falling-edge strobe and bit_cnt.
  - Outputs sclk, fall_strb, bit_cnt.
  - The top level owns the handshake, holding register and shift register.

Test Plan:
- Reset release, no smpl_vld:
  - First sclk fall at clk 32 after release; I2S_ws 1->0 there.
  - frame_start and underrun both pulse.
  - I2S_data stays 0 for 64 sclk.
  - ws period = 2048 clks, 50% duty.
- smpl_vld with L = 24'hA5A5A5, R = 24'h3C3C3C before the first frame:
  - smpl_rdy drops the next clk.
  - Receiver-style sampling on sclk rise yields bit 0 = 0, bits 1..24 = A5A5A5 MSB first, bits 25..31 = 0, bit 32 = 0, bits 33..56 = 3C3C3C, bits 57..63 = 0.
  - No underrun.
- smpl_vld held high with an incrementing pair each accept:
  - Exactly one accept per frame; smpl_rdy rises in the frame_start clk.
  - Frames carry consecutive pairs with no gaps or repeats.
- smpl_vld asserted in the exact frame_start clk with hold empty:
  - underrun pulses and that frame is zero.
  - The next frame carries the pair.
- rst asserted at bit_cnt = 40 mid right slot:
  - Next clk: sclk = 0, ws = 1, data = 0, smpl_rdy = 1.
  - Restart timing is identical to the first scenario.
- Loopback into the Equalizer I2S receiver with L = 24'h800000, R = 24'h7FFFFF:
  - Receiver reports exact values; its valid strobe is aligned once per ws period.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared widths, sample-pair type and frame layout for the I2S transmitter.
package i2s_pkg;

  localparam int SMPL_W     = 24;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 64;
  localparam int PAD_W      = SLOT_W - SMPL_W - 1;

  typedef struct packed {
    logic [SMPL_W-1:0] lft;
    logic [SMPL_W-1:0] rght;
  } smpl_pair_t;

  // Each slot opens with one zero bit so the MSB lands one sclk after the ws edge.
  function automatic logic [FRAME_BITS-1:0] build_frame(input smpl_pair_t p);
    return {1'b0, p.lft, {PAD_W{1'b0}}, 1'b0, p.rght, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider, falling-edge strobe and 64-position bit counter.
module i2s_clk_gen #(
  parameter int SCLK_HALF = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sclk,
  output logic       fall_strb,
  output logic [5:0] bit_cnt
);

  localparam int DIV_W = (SCLK_HALF > 2) ? $clog2(SCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCLK_HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_tc;

  assign div_tc    = (div_cnt == DIV_TC);
  // High in the clk whose edge drives sclk from 1 to 0.
  assign fall_strb = div_tc & sclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      bit_cnt <= 6'd63;
    end else begin
      if (div_tc) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall_strb) begin
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/i2s_xmtr.sv
// Master-mode I2S transmitter: one-deep sample holding register feeding a 64-bit frame shifter.
module i2s_xmtr
  import i2s_pkg::*;
#(
  parameter int SCLK_HALF = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SMPL_W-1:0] lft_smpl,
  input  logic [SMPL_W-1:0] rght_smpl,
  input  logic              smpl_vld,
  output logic              smpl_rdy,
  output logic              I2S_sclk,
  output logic              I2S_ws,
  output logic              I2S_data,
  output logic              frame_start,
  output logic              underrun
);

  logic                  fall_strb;
  logic [5:0]            bit_cnt;
  logic [5:0]            nxt_bit;
  logic                  load;
  logic                  capture;
  logic                  hold_full;
  smpl_pair_t            hold;
  logic [FRAME_BITS-1:0] frame_vec;
  logic [FRAME_BITS-1:0] shreg;

  i2s_clk_gen #(
    .SCLK_HALF (SCLK_HALF)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .sclk      (I2S_sclk),
    .fall_strb (fall_strb),
    .bit_cnt   (bit_cnt)
  );

  assign nxt_bit   = bit_cnt + 6'd1;
  assign load      = fall_strb & (bit_cnt == 6'd63);
  assign capture   = smpl_vld & ~hold_full;
  assign smpl_rdy  = ~hold_full;
  assign frame_vec = build_frame(hold);

  // Holding register payload carries no control meaning, so it is left unreset.
  always_ff @(posedge clk) begin
    if (capture) begin
      hold <= '{lft: lft_smpl, rght: rght_smpl};
    end
  end

  // A capture coinciding with an empty-hold load fills hold for the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end else if (capture) begin
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      I2S_ws      <= 1'b1;
      I2S_data    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (fall_strb) begin
        I2S_ws <= nxt_bit[5];
        if (load) begin
          frame_start <= 1'b1;
          if (hold_full) begin
            shreg    <= frame_vec;
            I2S_data <= frame_vec[FRAME_BITS-1];
          end else begin
            shreg    <= '0;
            I2S_data <= 1'b0;
            underrun <= 1'b1;
          end
        end else begin
          shreg    <= shreg << 1;
          I2S_data <= shreg[FRAME_BITS-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_xmtr.sv
// Directed bench for i2s_xmtr: reset, frame timing, handshake, underrun, mid-frame reset, loopback values.
module tb_i2s_xmtr;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] lft_smpl;
  logic [23:0] rght_smpl;
  logic        smpl_vld;
  logic        smpl_rdy;
  logic        I2S_sclk;
  logic        I2S_ws;
  logic        I2S_data;
  logic        frame_start;
  logic        underrun;

  int   errors = 0;
  int   checks = 0;
  int   nacc   = 0;
  int   pair_k = 0;
  logic prod_en = 1'b0;

  always #5 clk = ~clk;

  i2s_xmtr #(.SCLK_HALF(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .lft_smpl    (lft_smpl),
    .rght_smpl   (rght_smpl),
    .smpl_vld    (smpl_vld),
    .smpl_rdy    (smpl_rdy),
    .I2S_sclk    (I2S_sclk),
    .I2S_ws      (I2S_ws),
    .I2S_data    (I2S_data),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk; the incrementing producer advances to its next pair after each accept.
  task automatic step();
    logic acc;
    acc = smpl_vld & smpl_rdy;
    @(posedge clk);
    #1;
    if (acc) begin
      nacc++;
      if (prod_en) begin
        pair_k++;
        lft_smpl  = 24'h000100 + 24'(pair_k);
        rght_smpl = 24'hF00000 + 24'(pair_k);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 2100);
    chk(tag, 64'(frame_start), 64'd1);
  endtask

  // Receiver-style capture: sample I2S_data on 64 consecutive sclk rising edges.
  task automatic get_frame(input string tag, output logic [63:0] f);
    int   got;
    int   n;
    logic prev;
    f    = '0;
    got  = 0;
    n    = 0;
    prev = I2S_sclk;
    while (got < 64 && n < 2200) begin
      step();
      n++;
      if (I2S_sclk && !prev) begin
        f = {f[62:0], I2S_data};
        got++;
      end
      prev = I2S_sclk;
    end
    chk(tag, 64'(got), 64'd64);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_sclk"},  64'(I2S_sclk),    64'd0);
    chk({pfx, "_ws"},    64'(I2S_ws),      64'd1);
    chk({pfx, "_data"},  64'(I2S_data),    64'd0);
    chk({pfx, "_rdy"},   64'(smpl_rdy),    64'd1);
    chk({pfx, "_fs"},    64'(frame_start), 64'd0);
    chk({pfx, "_ur"},    64'(underrun),    64'd0);
  endtask

  task automatic chk_first_frame(input string pfx);
    steps(16);
    chk({pfx, "_rise"},   64'(I2S_sclk),    64'd1);
    steps(15);
    chk({pfx, "_pre_sclk"}, 64'(I2S_sclk),  64'd1);
    chk({pfx, "_pre_fs"},   64'(frame_start), 64'd0);
    chk({pfx, "_pre_ws"},   64'(I2S_ws),    64'd1);
    step();
    chk({pfx, "_fall"},   64'(I2S_sclk),    64'd0);
    chk({pfx, "_fs"},     64'(frame_start), 64'd1);
    chk({pfx, "_ur"},     64'(underrun),    64'd1);
    chk({pfx, "_ws"},     64'(I2S_ws),      64'd0);
  endtask

  initial begin
    logic [63:0] f;
    logic        dor;

    rst       = 1'b1;
    smpl_vld  = 1'b0;
    lft_smpl  = '0;
    rght_smpl = '0;
    #1;
    steps(3);
    chk_reset("reset");

    // Idle start: first fall 32 clks after release, zero frames, 2048-clk ws period.
    rst = 1'b0;
    chk_first_frame("idle");
    dor = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      step();
      dor |= I2S_data;
    end
    chk("ws_low_half", 64'(I2S_ws), 64'd0);
    step();
    dor |= I2S_data;
    chk("ws_rise", 64'(I2S_ws), 64'd1);
    for (int i = 0; i < 1023; i++) begin
      step();
      dor |= I2S_data;
    end
    chk("ws_high_half", 64'(I2S_ws), 64'd1);
    chk("idle_data_zero", 64'(dor), 64'd0);
    step();
    chk("ws_period_fall", 64'(I2S_ws), 64'd0);
    chk("idle_fs2", 64'(frame_start), 64'd1);
    chk("idle_ur2", 64'(underrun), 64'd1);

    // Single pair A5A5A5 / 3C3C3C.
    lft_smpl  = 24'hA5A5A5;
    rght_smpl = 24'h3C3C3C;
    smpl_vld  = 1'b1;
    step();
    chk("a5_rdy_drop", 64'(smpl_rdy), 64'd0);
    smpl_vld = 1'b0;
    wait_fs("a5_fs");
    chk("a5_no_ur", 64'(underrun), 64'd0);
    chk("a5_rdy_back", 64'(smpl_rdy), 64'd1);
    get_frame("a5_len", f);
    chk("a5_frame", f, 64'h52D2D280_1E1E1E00);

    // Streaming producer with incrementing pairs.
    nacc      = 0;
    pair_k    = 1;
    prod_en   = 1'b1;
    lft_smpl  = 24'h000101;
    rght_smpl = 24'hF00001;
    smpl_vld  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_fs("strm_fs");
      chk("strm_no_ur", 64'(underrun), 64'd0);
      chk("strm_rdy_rise", 64'(smpl_rdy), 64'd1);
      chk("strm_one_accept", 64'(nacc), 64'(i));
      get_frame("strm_len", f);
      chk("strm_left", 64'(f[62:39]), 64'(24'h000100 + 24'(i)));
      chk("strm_right", 64'(f[30:7]), 64'(24'hF00000 + 24'(i)));
    end
    smpl_vld = 1'b0;
    prod_en  = 1'b0;
    wait_fs("drain_fs");
    chk("drain_no_ur", 64'(underrun), 64'd0);

    // Capture in the same clk as an empty-hold frame load.
    steps(2047);
    lft_smpl  = 24'h123456;
    rght_smpl = 24'hABCDEF;
    smpl_vld  = 1'b1;
    step();
    smpl_vld = 1'b0;
    chk("sim_fs", 64'(frame_start), 64'd1);
    chk("sim_ur", 64'(underrun), 64'd1);
    chk("sim_rdy", 64'(smpl_rdy), 64'd0);
    get_frame("sim_zero_len", f);
    chk("sim_zero_frame", f, 64'd0);
    wait_fs("sim_next_fs");
    chk("sim_next_no_ur", 64'(underrun), 64'd0);
    get_frame("sim_next_len", f);
    chk("sim_next_frame", f, 64'h091A2B00_55E6F780);

    // Reset at bit 40 of a frame of all-ones samples with a pending pair.
    lft_smpl  = 24'hFFFFFF;
    rght_smpl = 24'hFFFFFF;
    smpl_vld  = 1'b1;
    step();
    smpl_vld = 1'b0;
    wait_fs("mid_fs");
    lft_smpl  = 24'h111111;
    rght_smpl = 24'h222222;
    smpl_vld  = 1'b1;
    step();
    smpl_vld = 1'b0;
    steps(1279);
    chk("mid_data_one", 64'(I2S_data), 64'd1);
    chk("mid_ws_right", 64'(I2S_ws), 64'd1);
    chk("mid_rdy_full", 64'(smpl_rdy), 64'd0);
    rst = 1'b1;
    step();
    chk_reset("midrst");
    rst = 1'b0;
    chk_first_frame("restart");

    // Loopback extremes.
    lft_smpl  = 24'h800000;
    rght_smpl = 24'h7FFFFF;
    smpl_vld  = 1'b1;
    step();
    smpl_vld = 1'b0;
    wait_fs("lb_fs");
    chk("lb_no_ur", 64'(underrun), 64'd0);
    get_frame("lb_len", f);
    chk("lb_frame", f, 64'h40000000_3FFFFF80);
    chk("lb_left", 64'(f[62:39]), 64'h800000);
    chk("lb_right", 64'(f[30:7]), 64'h7FFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
